// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the register file, with a reservation scoreboard.
// Requester A (pipeline) has priority; B (coprocessor) is force-granted after MAX_WAIT blocked cycles.
module regfile_wb_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned W_REG    = 5,
    parameter int unsigned W_CPU    = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             a_valid,
    output logic             a_ready,
    input  logic [W_REG-1:0] a_wa,
    input  logic [W_CPU-1:0] a_wd,

    input  logic             b_valid,
    output logic             b_ready,
    input  logic [W_REG-1:0] b_wa,
    input  logic [W_CPU-1:0] b_wd,

    input  logic             rsv_valid,
    input  logic [W_REG-1:0] rsv_wa,

    input  logic [W_REG-1:0] ra1,
    input  logic [W_REG-1:0] ra2,
    output logic             hazard1,
    output logic             hazard2,

    output logic             rf_wren,
    output logic [W_REG-1:0] rf_wa,
    output logic [W_CPU-1:0] rf_wd,
    output logic [31:0]      busy
);

    typedef enum logic [0:0] {StPrioA, StForceB} state_e;

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic [31:0] busy_d;

    logic             a_xfer, b_xfer, any_xfer;
    logic [W_REG-1:0] wr_wa;
    logic [W_CPU-1:0] wr_wd;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StPrioA;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StPrioA: begin
                if (b_valid && !b_ready) begin
                    if (wait_q == 4'(MAX_WAIT - 1)) begin
                        state_d = StForceB;
                        wait_d  = 4'd0;
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
                end else begin
                    wait_d = 4'd0;
                end
            end
            StForceB: begin
                wait_d = 4'd0;
                if (b_xfer || !b_valid) begin
                    state_d = StPrioA;
                end
            end
            default: begin
                state_d = StPrioA;
                wait_d  = 4'd0;
            end
        endcase
    end

    // Output logic: readies are combinational from state and valids
    always_comb begin
        a_ready = 1'b1;
        b_ready = 1'b0;
        unique case (state_q)
            StPrioA: begin
                a_ready = 1'b1;
                b_ready = !a_valid;
            end
            StForceB: begin
                b_ready = 1'b1;
                a_ready = !b_valid;
            end
            default: begin
                a_ready = 1'b1;
                b_ready = 1'b0;
            end
        endcase
    end

    // The ready rules make a_xfer and b_xfer mutually exclusive.
    assign a_xfer   = a_valid && a_ready;
    assign b_xfer   = b_valid && b_ready;
    assign any_xfer = a_xfer || b_xfer;
    assign wr_wa    = b_xfer ? b_wa : a_wa;
    assign wr_wd    = b_xfer ? b_wd : a_wd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wren <= 1'b0;
            rf_wa   <= '0;
            rf_wd   <= '0;
        end else begin
            rf_wren <= any_xfer && (wr_wa != '0);
            if (any_xfer) begin
                rf_wa <= wr_wa;
                rf_wd <= wr_wd;
            end
        end
    end

    // Reserve is applied after the B clear so a same-register collision stays reserved.
    always_comb begin
        busy_d = busy;
        if (b_xfer) begin
            busy_d[b_wa] = 1'b0;
        end
        if (rsv_valid && (rsv_wa != '0)) begin
            busy_d[rsv_wa] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_d;
        end
    end

    assign hazard1 = busy[ra1] && (ra1 != '0);
    assign hazard2 = busy[ra2] && (ra2 != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a cycle-level reference model.
// The model tracks how long B has been starved rather than an explicit FSM.
module tb_regfile_wb_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        rst;
    logic        a_valid, a_ready, b_valid, b_ready, rsv_valid;
    logic [4:0]  a_wa, b_wa, rsv_wa, ra1, ra2, rf_wa;
    logic [31:0] a_wd, b_wd, rf_wd, busy;
    logic        hazard1, hazard2, rf_wren;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          b_wait;
    bit [31:0]   m_busy;
    bit          m_wren;
    bit [4:0]    m_wa;
    bit [31:0]   m_wd;
    logic        last_a_ready;

    regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .W_REG(5), .W_CPU(32)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_wa(a_wa), .a_wd(a_wd),
        .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd),
        .rsv_valid(rsv_valid), .rsv_wa(rsv_wa),
        .ra1(ra1), .ra2(ra2), .hazard1(hazard1), .hazard2(hazard2),
        .rf_wren(rf_wren), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic av, input logic [4:0] awa, input logic [31:0] awd,
                        input logic bv, input logic [4:0] bwa, input logic [31:0] bwd,
                        input logic rv, input logic [4:0] rwa,
                        input logic [4:0] r1, input logic [4:0] r2);
        bit b_prio, ea, eb, axf, bxf;
        @(negedge clk);
        a_valid = av; a_wa = awa; a_wd = awd;
        b_valid = bv; b_wa = bwa; b_wd = bwd;
        rsv_valid = rv; rsv_wa = rwa; ra1 = r1; ra2 = r2;
        #1;
        // B takes priority once it has been starved for MAX_WAIT cycles in a row.
        b_prio = (b_wait >= MAX_WAIT);
        ea = b_prio ? !bv : 1'b1;
        eb = b_prio ? 1'b1 : !av;
        last_a_ready = a_ready;
        check_eq("a_ready", 32'(a_ready), 32'(ea));
        check_eq("b_ready", 32'(b_ready), 32'(eb));
        check_eq("hazard1", 32'(hazard1), 32'(m_busy[r1] && r1 != 0));
        check_eq("hazard2", 32'(hazard2), 32'(m_busy[r2] && r2 != 0));
        axf = av && ea;
        bxf = bv && eb;
        m_wren = 1'b0;
        if (bxf) begin
            m_wren = (bwa != 0); m_wa = bwa; m_wd = bwd;
        end else if (axf) begin
            m_wren = (awa != 0); m_wa = awa; m_wd = awd;
        end
        if (bxf) m_busy[bwa] = 1'b0;
        if (rv && rwa != 0) m_busy[rwa] = 1'b1;
        b_wait = (bv && !bxf) ? b_wait + 1 : 0;
        @(posedge clk);
        #1;
        check_eq("rf_wren", 32'(rf_wren), 32'(m_wren));
        if (m_wren) begin
            check_eq("rf_wa", 32'(rf_wa), 32'(m_wa));
            check_eq("rf_wd", rf_wd, m_wd);
        end
        check_eq("busy", busy, m_busy);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    // Assert reset in the middle of a cycle, check async effect, then release idle.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_rf_wren", 32'(rf_wren), 32'd0);
        check_eq("rst_busy", busy, 32'd0);
        check_eq("rst_a_ready", 32'(a_ready), 32'd1);
        check_eq("rst_b_ready", 32'(b_ready), 32'(!a_valid));
        @(posedge clk);
        #1;
        check_eq("rst_hold_wren", 32'(rf_wren), 32'd0);
        b_wait = 0; m_busy = '0; m_wren = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; rsv_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b1; a_wa = 5'd5; a_wd = 32'hA5A5_0001;
        b_valid = 1'b0; b_wa = '0; b_wd = '0;
        rsv_valid = 1'b0; rsv_wa = '0; ra1 = '0; ra2 = '0;
        b_wait = 0; m_busy = '0; m_wren = 1'b0; m_wa = '0; m_wd = '0;

        // V1: reset with a pending request, then first edge after release transfers
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("v1_rf_wren", 32'(rf_wren), 32'd0);
        check_eq("v1_busy", busy, 32'd0);
        check_eq("v1_a_ready", 32'(a_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("v1_wren", 32'(rf_wren), 32'd1);
        check_eq("v1_wa", 32'(rf_wa), 32'd5);
        check_eq("v1_wd", rf_wd, 32'hA5A5_0001);
        idle();

        // V2: continuous contention gives B one slot every MAX_WAIT+1 cycles
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 5'(i + 1), 32'h1000 + 32'(i), 1'b1, 5'd20, 32'h2000 + 32'(i),
                 1'b0, 5'd0, 5'd0, 5'd0);
            check_eq("v2_a_ready", 32'(last_a_ready), 32'((i % 5) != 4));
        end
        idle();

        // V3: write to r0 handshakes but does not write
        step(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        check_eq("v3_wren", 32'(rf_wren), 32'd0);

        // V4: reserve r9, see hazard, clear by B writeback
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        check_eq("v4_hazard1", 32'(hazard1), 32'd1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 5'd9, 5'd0);
        check_eq("v4_rf_wa", 32'(rf_wa), 32'd9);
        check_eq("v4_rf_wd", rf_wd, 32'h1234);
        check_eq("v4_busy9", 32'(busy[9]), 32'd0);
        check_eq("v4_hazard1_clr", 32'(hazard1), 32'd0);

        // V5: same-cycle reserve and B clear of r7: reserve wins
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 5'd0, 5'd0);
        check_eq("v5_busy7", 32'(busy[7]), 32'd1);
        check_eq("v5_rf_wa", 32'(rf_wa), 32'd7);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0, 5'd0, 5'd0);
        check_eq("v5_busy_clear", busy, 32'd0);

        // A write to a busy register leaves it reserved; re-reserve is harmless
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd0, 5'd0);
        step(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd8, 5'd8);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0);
        check_eq("v6_busy_pre", busy, 32'h0000_0300);

        // V6: reach forced-B state with a pending write, then reset mid-cycle
        for (int i = 0; i < MAX_WAIT; i++) begin
            step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd0, 5'd0);
        end
        check_eq("v6_pending", 32'(rf_wren), 32'd1);
        @(negedge clk);
        #1;
        check_eq("v6_force_b", 32'(a_ready), 32'd0);
        do_reset();

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 15)), $urandom,
                     1'($urandom_range(0, 4) < 3), 5'($urandom_range(0, 15)), $urandom,
                     1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 15)),
                     5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, max cycles B may be blocked before forced grant (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-low (asserted at 0).
REQ-004 SHALL have port a_valid  input  1  pipeline writeback request (requester A).
REQ-005 SHALL have port a_ready  output  1  A transfer accepted this cycle.
REQ-006 SHALL have port a_wa  input  W_REG  A destination register.
REQ-007 SHALL have port a_wd  input  W_CPU  A write data.
REQ-008 SHALL have ports b_valid, b_ready, b_wa, b_wd with the same widths and meanings for the coprocessor result path (requester B).
REQ-009 SHALL have port rsv_valid  input  1  reserve a register for a future B result.
REQ-010 SHALL have port rsv_wa  input  W_REG  register to reserve.
REQ-011 SHALL have ports ra1, ra2  input  W_REG  decode-stage read addresses.
REQ-012 SHALL have ports hazard1, hazard2  output  1  ra1/ra2 target a reserved register.
REQ-013 SHALL have port rf_wren  output  1  register file write enable.
REQ-014 SHALL have ports rf_wa  output  W_REG and rf_wd  output  W_CPU  register file write address and data.
REQ-015 SHALL have port busy  output  32  scoreboard vector, bit i = register i reserved.

Function
REQ-016 A transfer SHALL occur on a cycle where valid and ready are both 1; at most one transfer per cycle.
REQ-017 FSM SHALL have two states: PRIO_A (reset state) and FORCE_B.
REQ-018 In PRIO_A: a_ready=1; b_ready = !a_valid.
REQ-019 In FORCE_B: b_ready=1; a_ready = !b_valid.
REQ-020 Ready outputs SHALL be combinational from state and valids; ready may be 1 with valid 0.
REQ-021 Wait counter (4 bits) SHALL increment each cycle in PRIO_A with b_valid=1 and b_ready=0, and clear on any B transfer or when b_valid=0.
REQ-022 PRIO_A -> FORCE_B on the edge where counter == MAX_WAIT-1 and B is still blocked; counter clears on entry.
REQ-023 FORCE_B -> PRIO_A after one B transfer or on any cycle b_valid=0.
REQ-024 Winning transfer SHALL drive rf_wren/rf_wa/rf_wd registered, exactly one cycle after the handshake; rf_wren=0 on cycles with no transfer.
REQ-025 Transfer with wa==0 SHALL be accepted (ready handshake completes) but rf_wren SHALL stay 0.
REQ-026 rsv_valid=1 SHALL set busy[rsv_wa] at the next edge; rsv_wa==0 ignored.
REQ-027 B transfer SHALL clear busy[b_wa] at the same edge it is registered.
REQ-028 Simultaneous reserve and B clear of the same register: set wins (busy stays 1).
REQ-029 A transfer to a busy register SHALL write normally and SHALL NOT change busy.
REQ-030 Reserving an already-busy register: no change, no error.
REQ-031 hazardN = busy[raN] && raN!=0, combinational from current busy (no bypass of same-cycle reserve/clear).

Reset
REQ-032 While rst=0: state=PRIO_A, counter=0, busy=0, rf_wren=0, rf_wa=0, rf_wd=0, asynchronously, regardless of clock.
REQ-033 Reset mid-operation SHALL discard the in-flight registered write (rf_wren forced 0) and all reservations; first transfer possible on first edge after rst=1.

Verification
V1 Reset: rst=0 with a_valid=1, a_wa=5 -> rf_wren=0, busy=0, a_ready=1; release, next edge transfer -> rf_wren=1, rf_wa=5 one cycle later.
V2 Contention: a_valid=1 and b_valid=1 every cycle, MAX_WAIT=4 -> A wins cycles 0-3, B granted cycle 4 (a_ready=0), A resumes cycle 5; repeats with period 5.
V3 Zero register: a_valid=1, a_wa=0, a_wd=0xDEADBEEF -> a_ready=1, rf_wren=0 next cycle.
V4 Scoreboard: rsv_valid, rsv_wa=9; then ra1=9 -> hazard1=1; B transfer b_wa=9, b_wd=0x1234 -> next cycle rf_wa=9, rf_wd=0x1234, busy[9]=0, hazard1=0.
V5 Simultaneous: rsv_wa=7 and B transfer b_wa=7 same cycle, busy[7] previously 1 -> busy[7] stays 1; rf_wa=7 written.
V6 Mid-op reset: busy=0x00000300, FORCE_B, pending write -> rst=0 mid-cycle -> busy=0, rf_wren=0, state PRIO_A immediately.
